// File: rtl/restoring_divider.sv
`default_nettype none
// ============================================================================
// Module      : restoring_divider
// Description : Sequential restoring divider, one quotient bit per clock.
//               Produces quotient and remainder of two WIDTH-bit operands
//               behind a start/done handshake. Define DIVIDER_SIGNED_EN to
//               build the two's-complement variant, which adds a FIXUP cycle
//               that applies the result signs.
// Revision    : 1.0 - initial release
// ============================================================================
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div0
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_ITER  = 3'd2,
`ifdef DIVIDER_SIGNED_EN
    S_FIXUP = 3'd4,
`endif
    S_DONE  = 3'd3
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] d_q;      // latched divisor (magnitude in signed builds)
  logic [WIDTH-1:0] q_q;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] r_q;      // partial remainder; always < divisor so WIDTH bits suffice
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH:0]   t_w;      // shifted partial remainder, one bit wider than R
  logic             ge_w;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] dvd_load_d;
  logic [WIDTH-1:0] dvs_load_d;

`ifdef DIVIDER_SIGNED_EN
  logic sq_q;                 // quotient must be negated
  logic sr_q;                 // remainder must be negated (follows dividend sign)
  logic sq_d;
  logic sr_d;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    t_w  = {r_q, q_q[WIDTH-1]};
    ge_w = (t_w >= {1'b0, d_q});
    if (ge_w) begin
      // Difference is below the divisor, so the top bit is always zero.
      r_d = WIDTH'(t_w - {1'b0, d_q});
    end else begin
      r_d = t_w[WIDTH-1:0];
    end
    q_d = {q_q[WIDTH-2:0], ge_w};
  end

  // Operand conditioning for LOAD: magnitudes and result signs when signed.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_load_d = dividend[WIDTH-1] ? (~dividend + ONE) : dividend;
    dvs_load_d = divisor[WIDTH-1]  ? (~divisor + ONE)  : divisor;
    sq_d       = dividend[WIDTH-1] ^ divisor[WIDTH-1];
    sr_d       = dividend[WIDTH-1];
`else
    dvd_load_d = dividend;
    dvs_load_d = divisor;
`endif
  end

  // Control FSM with the datapath registers and registered result outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      d_q       <= '0;
      q_q       <= '0;
      r_q       <= '0;
      cnt_q     <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div0      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      sq_q      <= 1'b0;
      sr_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            busy    <= 1'b1;
          end
        end

        S_LOAD: begin
          d_q   <= dvs_load_d;
          q_q   <= dvd_load_d;
          r_q   <= '0;
          cnt_q <= CNT_W'(WIDTH - 1);
          div0  <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
          sq_q  <= sq_d;
          sr_q  <= sr_d;
`endif
          if (divisor == '0) begin
            // Divide by zero short-circuits: all-ones quotient, dividend as remainder.
            quotient  <= '1;
            remainder <= dividend;
            div0      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            state_q <= S_ITER;
          end
        end

        S_ITER: begin
          r_q <= r_d;
          q_q <= q_d;
          if (cnt_q == '0) begin
`ifdef DIVIDER_SIGNED_EN
            state_q <= S_FIXUP;
`else
            quotient  <= q_d;
            remainder <= r_d;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_q   <= S_DONE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

`ifdef DIVIDER_SIGNED_EN
        S_FIXUP: begin
          // Truncating division: quotient sign from operand signs, remainder from dividend.
          quotient  <= sq_q ? (~q_q + ONE) : q_q;
          remainder <= sr_q ? (~r_q + ONE) : r_q;
          busy      <= 1'b0;
          done      <= 1'b1;
          state_q   <= S_DONE;
        end
`endif

        S_DONE: begin
          // Wait for the requester to drop start; never re-enters LOAD directly.
          if (!start) begin
            done    <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
